// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
//
// Iterative Booth multiplier. A single add/sub datapath is reused once per
// RUN cycle to build a 2*WIDTH-bit product. Both operands are extended by at
// least one bit before the iterations start. The extension is sign or zero,
// chosen per transaction. One Booth recoding therefore gives exact products
// for signed and unsigned operands, including most-negative * most-negative.
//
// Compile option:
//   BOOTH_RADIX4_EN  - when defined, each RUN cycle retires two multiplier bits
//                      (radix-4 recoding, digits 0/+-M/+-2M). Accept-to-valid
//                      latency is EW/2+2 cycles instead of EW+1. Products are
//                      bit-identical in both builds.
//
// Parameters:
//   WIDTH      operand width, 2..32
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (high only in IDLE)
//   in_a       multiplier (Q operand)
//   in_b       multiplicand (M operand)
//   in_signed  1 = two's-complement operands, 0 = unsigned (sampled at accept)
//   out_valid  product valid (DONE)
//   out_ready  consumer accepts product
//   out_p      2*WIDTH-bit product, held stable until accepted
//   busy       high while iterating (RUN)
// ---------------------------------------------------------------------------
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

`ifdef BOOTH_RADIX4_EN
  // Even extension width so the radix-4 digits tile the multiplier exactly.
  localparam int EW    = ((WIDTH + 1) % 2 == 0) ? (WIDTH + 1) : (WIDTH + 2);
  localparam int ITERS = EW / 2;
  // Two non-iterating RUN cycles follow the last digit, giving EW/2+2 cycles
  // from accept to out_valid.
  localparam int LAST  = ITERS + 1;
`else
  localparam int EW    = WIDTH + 1;
  localparam int ITERS = EW;
  // One non-iterating RUN cycle moves {A,Q} into the output register.
  localparam int LAST  = EW;
`endif

  localparam int CW = $clog2(EW + 1);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * EW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state;
  logic signed [EW-1:0] a_reg;
  logic [EW-1:0]        q_reg;
  logic                 q_1;
  logic signed [EW-1:0] m_reg;
  logic [CW-1:0]        count;

  logic [SW-1:0]        step_nx;
  logic                 iterate;

  // Sign- or zero-extend an operand to EW bits.
  function automatic logic signed [EW-1:0] ext_op(
    input logic [WIDTH-1:0] v,
    input logic             sgn
  );
    return {{(EW - WIDTH){sgn & v[WIDTH-1]}}, v};
  endfunction

`ifdef BOOTH_RADIX4_EN
  // One radix-4 iteration. The add is done in EW+1 bits so +-2M never loses
  // the sign. The {A,Q,q_1} triple is then shifted arithmetically right by
  // two. Returned packed as {A_next, Q_next, q_1_next}.
  function automatic logic [SW-1:0] booth_step(
    input logic signed [EW-1:0] a,
    input logic [EW-1:0]        q,
    input logic                 q1,
    input logic signed [EW-1:0] m
  );
    logic signed [EW:0] aw;
    logic signed [EW:0] mw;
    logic signed [EW:0] s;
    aw = {a[EW-1], a};
    mw = {m[EW-1], m};
    case ({q[1], q[0], q1})
      3'b001, 3'b010: s = aw + mw;
      3'b011:         s = aw + (mw <<< 1);
      3'b100:         s = aw - (mw <<< 1);
      3'b101, 3'b110: s = aw - mw;
      default:        s = aw;
    endcase
    return {s[EW], s, q[EW-1:1]};
  endfunction
`else
  // One radix-2 iteration. The add/sub is EW bits with wraparound, followed by
  // an arithmetic right shift of {A,Q,q_1} by one. Returned packed as
  // {A_next, Q_next, q_1_next}.
  function automatic logic [SW-1:0] booth_step(
    input logic signed [EW-1:0] a,
    input logic [EW-1:0]        q,
    input logic                 q1,
    input logic signed [EW-1:0] m
  );
    logic signed [EW-1:0] s;
    case ({q[0], q1})
      2'b10:   s = a - m;
      2'b01:   s = a + m;
      default: s = a;
    endcase
    return {s[EW-1], s, q};
  endfunction
`endif

  assign step_nx = booth_step(a_reg, q_reg, q_1, m_reg);
  assign iterate = (count < CW'(ITERS));

  // Handshake flags decode straight from the state register. An asynchronous
  // reset therefore drops out_valid/busy and raises in_ready with no clock edge.
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_reg <= '0;
      q_reg <= '0;
      q_1   <= 1'b0;
      m_reg <= '0;
      count <= '0;
      out_p <= '0;
    end else begin
      case (state)
        // Accept: load operands, clear accumulator and counter.
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= '0;
            q_reg <= ext_op(in_a, in_signed);
            q_1   <= 1'b0;
            m_reg <= ext_op(in_b, in_signed);
            count <= '0;
            state <= ST_RUN;
          end
        end

        // Iterate: one Booth step per cycle, then publish the product.
        ST_RUN: begin
          if (count == CW'(LAST)) begin
            // The cast keeps the low 2*WIDTH bits of {A,Q}. The true product
            // always fits there, so the extension bits above are redundant.
            out_p <= PW'({a_reg, q_reg});
            state <= ST_DONE;
          end else begin
            count <= count + CW'(1);
            if (iterate) begin
              a_reg <= step_nx[SW-1:EW+1];
              q_reg <= step_nx[EW:1];
              q_1   <= step_nx[0];
            end
          end
        end

        // Hold the product until the consumer takes it.
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;
  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 10;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_signed = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] out_p;

  int errors = 0;
  int checks = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: the mathematical product of the interpreted operands,
  // truncated to the output width.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic sgn);
    longint pa;
    longint pb;
    longint pr;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    pr = pa * pb;
    return pr[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle. Scrambles inputs during RUN,
  // then holds out_ready low for 'hold' cycles before accepting.
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [2*W-1:0] exp, input int hold);
    int  cyc;
    logic bad;
    check({tag, ".idle_rdy"}, 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      in_valid  = 1'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".latency"}, 64'(cyc), 64'(LAT));
    check({tag, ".run_ctl"}, 64'(bad), 64'd0);
    check({tag, ".prod"}, 64'(out_p), 64'(exp));
    check({tag, ".done_ctl"}, {61'd0, out_valid, in_ready, busy}, 64'b100);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, ".hold_prod"}, 64'(out_p), 64'(exp));
      check({tag, ".hold_ctl"}, {62'd0, out_valid, in_ready}, 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".released"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("reset_p", 64'(out_p), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products
    do_mul("neg16sq",  8'hF0, 8'hF0, 1'b1, 16'h0100, 0);
    do_mul("m107x32",  8'h95, 8'h20, 1'b1, 16'hF2A0, 0);
    do_mul("sevenx0",  8'h07, 8'h00, 1'b1, 16'h0000, 0);
    do_mul("minxmin",  8'h80, 8'h80, 1'b1, 16'h4000, 0);
    do_mul("minxmax",  8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    do_mul("u255sq",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    do_mul("s_m1sq",   8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    do_mul("backpres", 8'h9C, 8'h3B, 1'b1, model(8'h9C, 8'h3B, 1'b1), 5);

    // Randomized products
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      do_mul("rand", ra, rb, rs, model(ra, rb, rs), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of RUN
    in_a = 8'd5; in_b = 8'd6; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ctl", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("midrun_rst_p", 64'(out_p), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_mul("after_rst", 8'd5, 8'd6, 1'b0, 16'd30, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
